// File: rtl/cpu5_decode_pipe_pkg.sv
// Shared encodings for the cpu5 decode stage: opcodes, control-field codes,
// the decoded control bundle and small decode helpers.
package cpu5_decode_pipe_pkg;

  localparam int CPU5_ALU_OP_SIZE = 4;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_BLT  = 3'b011;
  localparam logic [2:0] BR_BGE  = 3'b100;
  localparam logic [2:0] BR_BLTU = 3'b101;
  localparam logic [2:0] BR_BGEU = 3'b110;

  localparam logic [2:0] IMM_R = 3'b000;
  localparam logic [2:0] IMM_I = 3'b001;
  localparam logic [2:0] IMM_S = 3'b010;
  localparam logic [2:0] IMM_B = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;
  localparam logic [2:0] IMM_J = 3'b101;

  localparam logic [CPU5_ALU_OP_SIZE-1:0] ALU_ADD   = 4'b0000;
  localparam logic [CPU5_ALU_OP_SIZE-1:0] ALU_SUB   = 4'b0001;
  localparam logic [CPU5_ALU_OP_SIZE-1:0] ALU_SLL   = 4'b0010;
  localparam logic [CPU5_ALU_OP_SIZE-1:0] ALU_SLT   = 4'b0011;
  localparam logic [CPU5_ALU_OP_SIZE-1:0] ALU_SLTU  = 4'b0100;
  localparam logic [CPU5_ALU_OP_SIZE-1:0] ALU_XOR   = 4'b0101;
  localparam logic [CPU5_ALU_OP_SIZE-1:0] ALU_SRL   = 4'b0110;
  localparam logic [CPU5_ALU_OP_SIZE-1:0] ALU_SRA   = 4'b0111;
  localparam logic [CPU5_ALU_OP_SIZE-1:0] ALU_OR    = 4'b1000;
  localparam logic [CPU5_ALU_OP_SIZE-1:0] ALU_AND   = 4'b1001;
  localparam logic [CPU5_ALU_OP_SIZE-1:0] ALU_PASSB = 4'b1010;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_JAL  = 2'b01;
  localparam logic [1:0] JMP_JALR = 2'b10;

  typedef struct packed {
    logic [4:0]                  rd;
    logic [4:0]                  rs1;
    logic [4:0]                  rs2;
    logic                        memtoreg;
    logic                        memwrite;
    logic [1:0]                  memsize;
    logic                        memunsigned;
    logic [2:0]                  branchtype;
    logic                        alusrc;
    logic                        alusrca;
    logic                        regwrite;
    logic [1:0]                  jump;
    logic [CPU5_ALU_OP_SIZE-1:0] aluop;
    logic [2:0]                  immtype;
    logic                        illegal;
  } ctrl_t;

  // BR_NONE for the two undefined funct3 codes, which the decoder flags as illegal.
  function automatic logic [2:0] branch_cond(input logic [2:0] funct3);
    case (funct3)
      3'b000:  return BR_BEQ;
      3'b001:  return BR_BNE;
      3'b100:  return BR_BLT;
      3'b101:  return BR_BGE;
      3'b110:  return BR_BLTU;
      3'b111:  return BR_BGEU;
      default: return BR_NONE;
    endcase
  endfunction

  function automatic logic [CPU5_ALU_OP_SIZE-1:0] alu_from_funct3(input logic [2:0] funct3,
                                                                  input logic alt);
    case (funct3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/cpu5_decode_pipe_if.sv
// Fetch-side and execute-side handshake bundle of the cpu5 decode stage.
interface cpu5_decode_pipe_if #(parameter int XLEN = 32);
  import cpu5_decode_pipe_pkg::*;

  logic                        in_valid;
  logic                        in_ready;
  logic [31:0]                 in_instr;
  logic [XLEN-1:0]             in_pc;

  logic                        out_valid;
  logic                        out_ready;
  logic [XLEN-1:0]             out_pc;
  logic [XLEN-1:0]             out_imm;
  logic [4:0]                  out_rd;
  logic [4:0]                  out_rs1;
  logic [4:0]                  out_rs2;
  logic                        out_memtoreg;
  logic                        out_memwrite;
  logic [1:0]                  out_memsize;
  logic                        out_memunsigned;
  logic [2:0]                  out_branchtype;
  logic                        out_alusrc;
  logic                        out_alusrca;
  logic                        out_regwrite;
  logic [1:0]                  out_jump;
  logic [CPU5_ALU_OP_SIZE-1:0] out_aluop;
  logic [2:0]                  out_immtype;
  logic                        out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_imm, out_rd, out_rs1, out_rs2,
           out_memtoreg, out_memwrite, out_memsize, out_memunsigned,
           out_branchtype, out_alusrc, out_alusrca, out_regwrite, out_jump,
           out_aluop, out_immtype, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_imm, out_rd, out_rs1, out_rs2,
           out_memtoreg, out_memwrite, out_memsize, out_memunsigned,
           out_branchtype, out_alusrc, out_alusrca, out_regwrite, out_jump,
           out_aluop, out_immtype, out_illegal
  );
endinterface

// File: rtl/cpu5_decode_logic.sv
// Purely combinational RV32I decoder: instruction word to control bundle
// plus sign-extended immediate.
module cpu5_decode_logic
  import cpu5_decode_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output ctrl_t           ctrl,
  output logic [XLEN-1:0] imm
);

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic               ill;
  logic signed [31:0] imm32;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    ctrl     = '0;
    ill      = 1'b0;
    ctrl.rd  = instr[11:7];
    ctrl.rs1 = instr[19:15];
    ctrl.rs2 = instr[24:20];

    case (opcode)
      OPC_LUI: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluop    = ALU_PASSB;
        ctrl.immtype  = IMM_U;
      end
      OPC_AUIPC: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.alusrca  = 1'b1;
        ctrl.immtype  = IMM_U;
      end
      OPC_JAL: begin
        ctrl.jump     = JMP_JAL;
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.alusrca  = 1'b1;
        ctrl.immtype  = IMM_J;
      end
      OPC_JALR: begin
        ctrl.jump     = JMP_JALR;
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.immtype  = IMM_I;
        ill           = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        ctrl.branchtype = branch_cond(funct3);
        ctrl.aluop      = ALU_SUB;
        ctrl.immtype    = IMM_B;
        ill             = (ctrl.branchtype == BR_NONE);
      end
      OPC_LOAD: begin
        ctrl.memtoreg    = 1'b1;
        ctrl.regwrite    = 1'b1;
        ctrl.alusrc      = 1'b1;
        ctrl.immtype     = IMM_I;
        ctrl.memsize     = funct3[1:0];
        ctrl.memunsigned = funct3[2];
        ill              = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        ctrl.memwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.immtype  = IMM_S;
        ctrl.memsize  = funct3[1:0];
        ill           = funct3[2] || (funct3[1:0] == 2'b11);
      end
      OPC_OPIMM: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.immtype  = IMM_I;
        // Only the shift-immediates carry a funct7; elsewhere bit 30 is immediate data.
        ctrl.aluop    = alu_from_funct3(funct3, (funct3 == 3'b101) && funct7[5]);
        if (funct3 == 3'b001)
          ill = (funct7 != 7'b0000000);
        else if (funct3 == 3'b101)
          ill = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
      end
      OPC_OP: begin
        ctrl.regwrite = 1'b1;
        ctrl.immtype  = IMM_R;
        ctrl.aluop    = alu_from_funct3(funct3, funct7[5]);
        ill = !((funct7 == 7'b0000000) ||
                ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OPC_FENCE: ;
      default: ill = 1'b1;
    endcase

    if (instr[1:0] != 2'b11)
      ill = 1'b1;

    if (ill) begin
      ctrl.regwrite   = 1'b0;
      ctrl.memwrite   = 1'b0;
      ctrl.memtoreg   = 1'b0;
      ctrl.jump       = JMP_NONE;
      ctrl.branchtype = BR_NONE;
    end
    ctrl.illegal = ill;
  end

  always_comb begin
    imm32 = '0;
    case (ctrl.immtype)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'h000};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'(imm32);

endmodule

// File: rtl/cpu5_decode_pipe.sv
// Registered decode stage: head entry plus optional skid entry, valid/ready
// on both sides, flush squashes everything held.
module cpu5_decode_pipe
  import cpu5_decode_pipe_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  cpu5_decode_pipe_if.slave   bus
);

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_HEAD  = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b10;

  logic [1:0]      state_q, state_d;
  logic            in_ready_q;
  logic            in_ready;
  logic            accept, drain;
  logic            load_head, load_skid, head_from_skid;

  ctrl_t           dec_ctrl;
  logic [XLEN-1:0] dec_imm;

  ctrl_t           head_ctrl_q, skid_ctrl_q;
  logic [XLEN-1:0] head_imm_q,  skid_imm_q;
  logic [XLEN-1:0] head_pc_q,   skid_pc_q;

  cpu5_decode_logic #(.XLEN(XLEN)) u_decode (
    .instr (bus.in_instr),
    .ctrl  (dec_ctrl),
    .imm   (dec_imm)
  );

  // Without a skid entry the stage can only accept when the head leaves this cycle.
  assign in_ready = (SKID != 0) ? in_ready_q
                                : ((state_q == ST_EMPTY) || bus.out_ready);
  assign accept   = bus.in_valid && in_ready && !flush;
  assign drain    = (state_q != ST_EMPTY) && bus.out_ready;

  always_comb begin
    state_d        = state_q;
    load_head      = 1'b0;
    load_skid      = 1'b0;
    head_from_skid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          load_head = 1'b1;
          state_d   = ST_HEAD;
        end
      end
      ST_HEAD: begin
        if (accept && drain) begin
          load_head = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_d   = ST_FULL;
        end else if (drain) begin
          state_d   = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (drain) begin
          head_from_skid = !flush;
          state_d        = ST_HEAD;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush)
      state_d = ST_EMPTY;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      head_ctrl_q <= '0;
      head_imm_q  <= '0;
      head_pc_q   <= '0;
      skid_ctrl_q <= '0;
      skid_imm_q  <= '0;
      skid_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
      if (load_head) begin
        head_ctrl_q <= dec_ctrl;
        head_imm_q  <= dec_imm;
        head_pc_q   <= bus.in_pc;
      end else if (head_from_skid) begin
        head_ctrl_q <= skid_ctrl_q;
        head_imm_q  <= skid_imm_q;
        head_pc_q   <= skid_pc_q;
      end
      if (load_skid) begin
        skid_ctrl_q <= dec_ctrl;
        skid_imm_q  <= dec_imm;
        skid_pc_q   <= bus.in_pc;
      end
    end
  end

  assign bus.in_ready        = in_ready;
  assign bus.out_valid       = (state_q != ST_EMPTY);
  assign bus.out_pc          = head_pc_q;
  assign bus.out_imm         = head_imm_q;
  assign bus.out_rd          = head_ctrl_q.rd;
  assign bus.out_rs1         = head_ctrl_q.rs1;
  assign bus.out_rs2         = head_ctrl_q.rs2;
  assign bus.out_memtoreg    = head_ctrl_q.memtoreg;
  assign bus.out_memwrite    = head_ctrl_q.memwrite;
  assign bus.out_memsize     = head_ctrl_q.memsize;
  assign bus.out_memunsigned = head_ctrl_q.memunsigned;
  assign bus.out_branchtype  = head_ctrl_q.branchtype;
  assign bus.out_alusrc      = head_ctrl_q.alusrc;
  assign bus.out_alusrca     = head_ctrl_q.alusrca;
  assign bus.out_regwrite    = head_ctrl_q.regwrite;
  assign bus.out_jump        = head_ctrl_q.jump;
  assign bus.out_aluop       = head_ctrl_q.aluop;
  assign bus.out_immtype     = head_ctrl_q.immtype;
  assign bus.out_illegal     = head_ctrl_q.illegal;

endmodule

// File: tb/tb_cpu5_decode_pipe.sv
// Directed bench for cpu5_decode_pipe: decode vectors, backpressure, flush,
// mid-stream reset, and the single-entry variant.
module tb_cpu5_decode_pipe;

  logic clk;
  logic reset;
  logic flush;

  cpu5_decode_pipe_if #(.XLEN(32)) bus ();
  cpu5_decode_pipe_if #(.XLEN(32)) bus0 ();

  cpu5_decode_pipe #(.XLEN(32), .SKID(1)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  cpu5_decode_pipe #(.XLEN(32), .SKID(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [3:0]  aluop;
    logic [2:0]  branchtype;
    logic [2:0]  immtype;
    logic        regwrite;
    logic        memtoreg;
    logic        memwrite;
    logic [1:0]  jump;
    logic        illegal;
  } vec_t;

  vec_t vecs[$];

  initial begin
    //            instr         imm           alu   br    imm   rw    mtr   mw    jmp    ill
    vecs.push_back('{32'hFFF10093, 32'hFFFFFFFF, 4'h0, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0}); // addi x1,x2,-1
    vecs.push_back('{32'h00208463, 32'h00000008, 4'h1, 3'd1, 3'd3, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0}); // beq +8
    vecs.push_back('{32'h00432283, 32'h00000004, 4'h0, 3'd0, 3'd1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0}); // lw
    vecs.push_back('{32'h0071A423, 32'h00000008, 4'h0, 3'd0, 3'd2, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0}); // sw
    vecs.push_back('{32'h12345537, 32'h12345000, 4'hA, 3'd0, 3'd4, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0}); // lui
    vecs.push_back('{32'h010000EF, 32'h00000010, 4'h0, 3'd0, 3'd5, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0}); // jal +16
    vecs.push_back('{32'h000280E7, 32'h00000000, 4'h0, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0}); // jalr
    vecs.push_back('{32'h402081B3, 32'h00000000, 4'h1, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0}); // sub
    vecs.push_back('{32'h40335293, 32'h00000403, 4'h7, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0}); // srai
    vecs.push_back('{32'hFE20EEE3, 32'hFFFFFFFC, 4'h1, 3'd5, 3'd3, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0}); // bltu -4
    vecs.push_back('{32'h0000000F, 32'h00000000, 4'h0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0}); // fence
    vecs.push_back('{32'hFFFFFFFF, 32'h00000000, 4'h0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1}); // bad opcode
    vecs.push_back('{32'h022081B3, 32'h00000000, 4'h0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1}); // funct7 01
    vecs.push_back('{32'h00433283, 32'h00000004, 4'h0, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1}); // load f3 011
    vecs.push_back('{32'hFFF10091, 32'h00000000, 4'h0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1}); // instr[1:0]=01
  end

  initial begin
    reset          = 1'b1;
    flush          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_instr   = '0;
    bus.in_pc      = '0;
    bus.out_ready  = 1'b0;
    bus0.in_valid  = 1'b0;
    bus0.in_instr  = '0;
    bus0.in_pc     = '0;
    bus0.out_ready = 1'b0;

    #12;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_imm",   64'(bus.out_imm),   64'd0);
    check("rst_out_pc",    64'(bus.out_pc),    64'd0);
    check("rst_out_rd",    64'(bus.out_rd),    64'd0);
    check("rst_out_aluop", 64'(bus.out_aluop), 64'd0);
    check("rst_out_ill",   64'(bus.out_illegal), 64'd0);
    reset = 1'b0;
    tick();
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Back-to-back decode stream, out_ready held high.
    bus.out_ready = 1'b1;
    foreach (vecs[i]) begin
      bus.in_valid = 1'b1;
      bus.in_instr = vecs[i].instr;
      bus.in_pc    = 32'h100 + 32'(i) * 4;
      tick();
      check($sformatf("v%0d_valid", i),   64'(bus.out_valid),      64'd1);
      check($sformatf("v%0d_pc", i),      64'(bus.out_pc),         64'(32'h100 + 32'(i) * 4));
      check($sformatf("v%0d_imm", i),     64'(bus.out_imm),        64'(vecs[i].imm));
      check($sformatf("v%0d_aluop", i),   64'(bus.out_aluop),      64'(vecs[i].aluop));
      check($sformatf("v%0d_br", i),      64'(bus.out_branchtype), 64'(vecs[i].branchtype));
      check($sformatf("v%0d_immtype", i), 64'(bus.out_immtype),    64'(vecs[i].immtype));
      check($sformatf("v%0d_rw", i),      64'(bus.out_regwrite),   64'(vecs[i].regwrite));
      check($sformatf("v%0d_mtr", i),     64'(bus.out_memtoreg),   64'(vecs[i].memtoreg));
      check($sformatf("v%0d_mw", i),      64'(bus.out_memwrite),   64'(vecs[i].memwrite));
      check($sformatf("v%0d_jump", i),    64'(bus.out_jump),       64'(vecs[i].jump));
      check($sformatf("v%0d_ill", i),     64'(bus.out_illegal),    64'(vecs[i].illegal));
      check($sformatf("v%0d_in_ready", i), 64'(bus.in_ready),      64'd1);
      if (i == 0) begin
        check("addi_rd",     64'(bus.out_rd),     64'd1);
        check("addi_rs1",    64'(bus.out_rs1),    64'd2);
        check("addi_alusrc", 64'(bus.out_alusrc), 64'd1);
      end
      if (i == 2) begin
        check("lw_memsize", 64'(bus.out_memsize), 64'd2);
        check("lw_rd",      64'(bus.out_rd),      64'd5);
      end
      if (i == 5)
        check("jal_alusrca", 64'(bus.out_alusrca), 64'd1);
    end
    bus.in_valid = 1'b0;
    tick();
    check("drain_empty", 64'(bus.out_valid), 64'd0);

    // Backpressure: A, B, C offered with out_ready low.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h00100093; // addi x1,x0,1
    bus.in_pc     = 32'h200;
    tick();
    check("bp_a_in_ready", 64'(bus.in_ready), 64'd1);
    bus.in_instr  = 32'h00200113; // addi x2,x0,2
    bus.in_pc     = 32'h204;
    tick();
    check("bp_full_in_ready", 64'(bus.in_ready), 64'd0);
    check("bp_full_pc",       64'(bus.out_pc),   64'h200);
    bus.in_instr  = 32'h00300193; // addi x3,x0,3
    bus.in_pc     = 32'h208;
    tick();
    check("bp_c_stall_ready", 64'(bus.in_ready), 64'd0);
    check("bp_hold_pc",       64'(bus.out_pc),   64'h200);
    check("bp_hold_imm",      64'(bus.out_imm),  64'd1);
    bus.out_ready = 1'b1;
    tick();
    check("bp_out2_pc",  64'(bus.out_pc),  64'h204);
    check("bp_out2_imm", 64'(bus.out_imm), 64'd2);
    tick();
    bus.in_valid = 1'b0;
    check("bp_out3_pc",    64'(bus.out_pc),    64'h208);
    check("bp_out3_rd",    64'(bus.out_rd),    64'd3);
    check("bp_out3_valid", 64'(bus.out_valid), 64'd1);
    tick();
    check("bp_done_valid", 64'(bus.out_valid), 64'd0);

    // Flush while FULL with a new instruction offered.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h00100093;
    bus.in_pc     = 32'h400;
    tick();
    bus.in_pc     = 32'h404;
    tick();
    check("fl_full_in_ready", 64'(bus.in_ready), 64'd0);
    flush         = 1'b1;
    bus.in_pc     = 32'h4F0;
    tick();
    check("fl_out_valid", 64'(bus.out_valid), 64'd0);
    check("fl_in_ready",  64'(bus.in_ready),  64'd1);
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("fl_dropped", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset while FULL.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h00500293;
    bus.in_pc     = 32'h500;
    tick();
    bus.in_pc     = 32'h504;
    tick();
    check("rf_full_valid", 64'(bus.out_valid), 64'd1);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("rf_out_valid", 64'(bus.out_valid),    64'd0);
    check("rf_out_pc",    64'(bus.out_pc),       64'd0);
    check("rf_out_imm",   64'(bus.out_imm),      64'd0);
    check("rf_out_rw",    64'(bus.out_regwrite), 64'd0);
    check("rf_out_rd",    64'(bus.out_rd),       64'd0);
    #1;
    reset = 1'b0;
    #1;
    check("rf_in_ready", 64'(bus.in_ready), 64'd1);
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'hFFF10093;
    bus.in_pc     = 32'h600;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("rf_first_valid", 64'(bus.out_valid), 64'd1);
    check("rf_first_pc",    64'(bus.out_pc),    64'h600);
    check("rf_first_imm",   64'(bus.out_imm),   64'hFFFFFFFF);
    check("rf_first_rd",    64'(bus.out_rd),    64'd1);
    tick();

    // Single-entry variant: combinational in_ready and replace-on-drain.
    bus0.in_valid = 1'b1;
    bus0.in_instr = 32'h00100093;
    bus0.in_pc    = 32'h300;
    #1;
    check("s0_empty_ready", 64'(bus0.in_ready), 64'd1);
    tick();
    check("s0_valid",       64'(bus0.out_valid), 64'd1);
    check("s0_pc",          64'(bus0.out_pc),    64'h300);
    check("s0_stall_ready", 64'(bus0.in_ready),  64'd0);
    bus0.in_pc = 32'h304;
    tick();
    check("s0_held_pc", 64'(bus0.out_pc), 64'h300);
    bus0.out_ready = 1'b1;
    #1;
    check("s0_comb_ready", 64'(bus0.in_ready), 64'd1);
    tick();
    check("s0_replace_pc",    64'(bus0.out_pc),    64'h304);
    check("s0_replace_valid", 64'(bus0.out_valid), 64'd1);
    bus0.in_valid = 1'b0;
    tick();
    check("s0_empty", 64'(bus0.out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
